// File: rtl/obs_split_sched_117bit_if.sv
// Handshake and data bundle for the OBS split scheduler: operand input,
// shared sub-multiplier request/response, and the four sub-product outputs.
interface obs_split_sched_117bit_if #(
   parameter int N = 118,
   parameter int H = 59
);
   logic           in_valid;
   logic           in_ready;
   logic [N-2:0]   A_in;
   logic [N-2:0]   B_in;
   logic           sub_req_valid;
   logic           sub_req_ready;
   logic [H-1:0]   sub_a;
   logic [H-1:0]   sub_b;
   logic           sub_rsp_valid;
   logic [N-2:0]   sub_rsp;
   logic           out_valid;
   logic           out_ready;
   logic [N-2:0]   prod_ee;
   logic [N-2:0]   prod_eo;
   logic [N-2:0]   prod_oe;
   logic [N-2:0]   prod_oo;
   logic           err_rsp;

   // Scheduler side.
   modport slave (
      input  in_valid, A_in, B_in, sub_req_ready, sub_rsp_valid, sub_rsp, out_ready,
      output in_ready, sub_req_valid, sub_a, sub_b, out_valid,
             prod_ee, prod_eo, prod_oe, prod_oo, err_rsp
   );

   // Environment side: operand source, sub-multiplier and product sink.
   modport master (
      output in_valid, A_in, B_in, sub_req_ready, sub_rsp_valid, sub_rsp, out_ready,
      input  in_ready, sub_req_valid, sub_a, sub_b, out_valid,
             prod_ee, prod_eo, prod_oe, prod_oo, err_rsp
   );
endinterface

// File: rtl/obs_split_sched_117bit.sv
// Odd/even split front end: captures two 117-bit GF(2) operands and runs the four
// half-products through one shared 59-bit sub-multiplier, holding results until taken.
module obs_split_sched_117bit #(
   parameter int N = 118,
   parameter int H = 59
) (
   input  logic                    clk,
   input  logic                    rst,
   obs_split_sched_117bit_if.slave bus
);
   localparam int W = N - 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              idx_q, idx_d;
   logic [W-1:0]            a_q, a_d;
   logic [W-1:0]            b_q, b_d;
   logic [3:0][W-1:0]       prod_q, prod_d;
   logic [H-1:0]            sub_a_q, sub_a_d;
   logic [H-1:0]            sub_b_q, sub_b_d;
   logic                    err_q, err_d;
   logic                    rdy_q, rdy_d;
   logic [1:0]              idx_nxt;

   logic [H-1:0]            ae_in, ao_in, be_in, bo_in;
   logic [H-1:0]            ae_q, ao_q, be_q, bo_q;

   // Even/odd coefficient split of both the incoming and the captured operands;
   // the top odd coefficient does not exist and is padded with zero.
   for (genvar gi = 0; gi < H; gi++) begin : g_split
      assign ae_in[gi] = bus.A_in[2*gi];
      assign be_in[gi] = bus.B_in[2*gi];
      assign ae_q[gi]  = a_q[2*gi];
      assign be_q[gi]  = b_q[2*gi];
      if (2*gi + 1 < W) begin : g_odd
         assign ao_in[gi] = bus.A_in[2*gi+1];
         assign bo_in[gi] = bus.B_in[2*gi+1];
         assign ao_q[gi]  = a_q[2*gi+1];
         assign bo_q[gi]  = b_q[2*gi+1];
      end else begin : g_pad
         assign ao_in[gi] = 1'b0;
         assign bo_in[gi] = 1'b0;
         assign ao_q[gi]  = 1'b0;
         assign bo_q[gi]  = 1'b0;
      end
   end

   assign idx_nxt = idx_q + 2'd1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      prod_d  = prod_q;
      sub_a_d = sub_a_q;
      sub_b_d = sub_b_q;
      // Only WAIT expects a response; anything else is a protocol error.
      err_d   = err_q | (bus.sub_rsp_valid & (state_q != S_WAIT));

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && rdy_q) begin
               a_d     = bus.A_in;
               b_d     = bus.B_in;
               idx_d   = 2'd0;
               sub_a_d = ae_in;
               sub_b_d = be_in;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus.sub_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.sub_rsp_valid) begin
               prod_d[idx_q] = bus.sub_rsp;
               if (idx_q == 2'd3) begin
                  state_d = S_DONE;
               end else begin
                  // idx bit 1 picks the A half, bit 0 the B half.
                  idx_d   = idx_nxt;
                  sub_a_d = idx_nxt[1] ? ao_q : ae_q;
                  sub_b_d = idx_nxt[0] ? bo_q : be_q;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      rdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         prod_q  <= '0;
         sub_a_q <= '0;
         sub_b_q <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         prod_q  <= prod_d;
         sub_a_q <= sub_a_d;
         sub_b_q <= sub_b_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   assign bus.in_ready      = rdy_q;
   assign bus.sub_req_valid = (state_q == S_ISSUE);
   assign bus.sub_a         = sub_a_q;
   assign bus.sub_b         = sub_b_q;
   assign bus.out_valid     = (state_q == S_DONE);
   assign bus.prod_ee       = prod_q[0];
   assign bus.prod_eo       = prod_q[1];
   assign bus.prod_oe       = prod_q[2];
   assign bus.prod_oo       = prod_q[3];
   assign bus.err_rsp       = err_q;
endmodule

// File: tb/tb_obs_split_sched_117bit.sv
// Scoreboard bench for the OBS split scheduler with a behavioural sub-multiplier
// and a carry-less 117x117 reference product.
`timescale 1ns/1ps
module tb_obs_split_sched_117bit;
   localparam int W = 117;
   localparam int H = 59;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   obs_split_sched_117bit_if bus ();
   obs_split_sched_117bit dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;
   typedef struct { logic [H-1:0] a; logic [H-1:0] b; } req_t;

   op_t  exp_q[$];
   req_t req_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ops_done = 0;

   int rdy_mode = 0;      // 0: sub_req_ready always 1, 1: random
   int dly_mode = 0;      // >=0 fixed extra response delay, -1 random 0..6
   int oready_mode = 0;   // 0: out_ready always 1, 1: random
   int stall_idx = -1, stall_len = 0, stall_seen = 0;
   int done_hold = 0, done_seen = 0;
   bit inject = 1'b0;
   int acc_cnt = 0;
   int rsp_cnt = 0;
   logic [W-1:0] rsp_val;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got=event want=none", name);
   endtask

   function automatic logic [H-1:0] ev(input logic [W-1:0] x);
      logic [H-1:0] r;
      r = '0;
      for (int j = 0; j < H; j++) r[j] = x[2*j];
      return r;
   endfunction

   function automatic logic [H-1:0] od(input logic [W-1:0] x);
      logic [H-1:0] r;
      r = '0;
      for (int j = 0; j < H - 1; j++) r[j] = x[2*j+1];
      return r;
   endfunction

   function automatic logic [W-1:0] clmul59(input logic [H-1:0] a, input logic [H-1:0] b);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < H; i++) if (a[i]) r ^= W'(b) << i;
      return r;
   endfunction

   function automatic logic [2*W-2:0] clmul117(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-2:0] r;
      r = '0;
      for (int i = 0; i < W; i++) if (a[i]) r ^= (2*W-1)'(b) << i;
      return r;
   endfunction

   function automatic logic [2*W-2:0] spread(input logic [W-1:0] p);
      logic [2*W-2:0] r;
      r = '0;
      for (int i = 0; i < W; i++) r[2*i] = p[i];
      return r;
   endfunction

   // A*B = ee(x^2) + x*(eo+oe)(x^2) + x^2*oo(x^2)
   function automatic logic [2*W-2:0] overlap(input logic [W-1:0] ee, input logic [W-1:0] eo,
                                               input logic [W-1:0] oe, input logic [W-1:0] oo);
      return spread(ee) ^ (spread(eo ^ oe) << 1) ^ (spread(oo) << 2);
   endfunction

   function automatic logic [W-1:0] rnd117();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // Sub-multiplier model: accepts requests, answers 1+delay cycles later.
   initial begin
      bus.sub_req_ready = 1'b0;
      bus.sub_rsp_valid = 1'b0;
      bus.sub_rsp = '0;
      forever begin
         @(negedge clk);
         bus.sub_rsp_valid = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               bus.sub_rsp_valid = 1'b1;
               bus.sub_rsp = rsp_val;
            end
         end
         if (inject) begin
            bus.sub_rsp_valid = 1'b1;
            bus.sub_rsp = '1;
            inject = 1'b0;
         end
         if (bus.sub_req_valid && stall_seen < stall_len && (acc_cnt % 4) == stall_idx) begin
            bus.sub_req_ready = 1'b0;
            stall_seen++;
            if (req_q.size() > 0) begin
               chk("stall_sub_a", bus.sub_a, req_q[0].a);
               chk("stall_sub_b", bus.sub_b, req_q[0].b);
            end
         end else begin
            bus.sub_req_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.sub_req_valid && bus.sub_req_ready) begin
               req_t r;
               acc_cnt++;
               rsp_val = clmul59(bus.sub_a, bus.sub_b);
               rsp_cnt = 1 + ((dly_mode < 0) ? int'($urandom_range(0, 6)) : dly_mode);
               if (req_q.size() == 0) begin
                  fail_now("req_unexpected");
               end else begin
                  r = req_q.pop_front();
                  chk("req_a", bus.sub_a, r.a);
                  chk("req_b", bus.sub_b, r.b);
               end
            end
         end
      end
   end

   // Output monitor: pops the scoreboard on every product handshake.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.out_valid && done_seen < done_hold) begin
            bus.out_ready = 1'b0;
            done_seen++;
            chk("hold_in_ready", bus.in_ready, 0);
            if (exp_q.size() > 0) begin
               chk("hold_ee", bus.prod_ee, clmul59(ev(exp_q[0].a), ev(exp_q[0].b)));
               chk("hold_oo", bus.prod_oo, clmul59(od(exp_q[0].a), od(exp_q[0].b)));
            end
         end else begin
            bus.out_ready = (oready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  fail_now("out_unexpected");
               end else begin
                  op_t e;
                  e = exp_q.pop_front();
                  chk("prod_ee", bus.prod_ee, clmul59(ev(e.a), ev(e.b)));
                  chk("prod_eo", bus.prod_eo, clmul59(ev(e.a), od(e.b)));
                  chk("prod_oe", bus.prod_oe, clmul59(od(e.a), ev(e.b)));
                  chk("prod_oo", bus.prod_oo, clmul59(od(e.a), od(e.b)));
                  chk("overlap", overlap(bus.prod_ee, bus.prod_eo, bus.prod_oe, bus.prod_oo),
                      clmul117(e.a, e.b));
                  $display("op %0d a=%h b=%h", ops_done, e.a, e.b);
                  ops_done++;
               end
            end
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit check_lat);
      int n, t0;
      op_t e;
      req_t r;
      bus.in_valid = 1'b1;
      bus.A_in = a;
      bus.B_in = b;
      n = 0;
      while (!bus.in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) fail_now("in_ready_timeout");
      e.a = a; e.b = b;
      exp_q.push_back(e);
      r.a = ev(a); r.b = ev(b); req_q.push_back(r);
      r.a = ev(a); r.b = od(b); req_q.push_back(r);
      r.a = od(a); r.b = ev(b); req_q.push_back(r);
      r.a = od(a); r.b = od(b); req_q.push_back(r);
      t0 = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.A_in = rnd117();
      bus.B_in = rnd117();
      if (check_lat) begin
         n = 0;
         while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("latency", cyc - t0, 9);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) fail_now("drain_timeout");
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_sub_req_valid"}, bus.sub_req_valid, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_sub_a"}, bus.sub_a, 0);
      chk({tag, "_sub_b"}, bus.sub_b, 0);
      chk({tag, "_prods"}, {bus.prod_ee, bus.prod_eo, bus.prod_oe, bus.prod_oo}, 0);
   endtask

   initial begin
      int n, base;
      bus.in_valid = 1'b0;
      bus.A_in = '0;
      bus.B_in = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      chk("rst_err", bus.err_rsp, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // x^0 * x^0
      run_op(W'(1), W'(1), 1'b1);
      drain();
      chk("t1_ee", bus.prod_ee, 1);
      chk("t1_others", {bus.prod_eo, bus.prod_oe, bus.prod_oo}, 0);
      chk("t1_overlap", overlap(bus.prod_ee, bus.prod_eo, bus.prod_oe, bus.prod_oo), 1);

      // x * x
      run_op(W'(2), W'(2), 1'b0);
      drain();
      chk("t2_oo", bus.prod_oo, 1);
      chk("t2_others", {bus.prod_ee, bus.prod_eo, bus.prod_oe}, 0);
      chk("t2_overlap", overlap(bus.prod_ee, bus.prod_eo, bus.prod_oe, bus.prod_oo), 4);

      // Back-pressure on the idx 2 request and on the product handshake.
      stall_idx = 2; stall_len = 5; stall_seen = 0;
      done_hold = 10; done_seen = 0;
      run_op(rnd117(), rnd117(), 1'b0);
      drain();
      chk("stall_cycles", stall_seen, 5);
      chk("hold_cycles", done_seen, 10);
      stall_len = 0; done_hold = 0;

      // Randomised traffic.
      rdy_mode = 1; dly_mode = -1; oready_mode = 1;
      for (int i = 0; i < 1000; i++) begin
         if (i == 0) run_op('1, '1, 1'b0);
         else if (i == 1) run_op('1, W'(1) << (W - 1), 1'b0);
         else run_op(rnd117(), rnd117(), 1'b0);
      end
      drain();
      chk("rand_err", bus.err_rsp, 0);
      chk("rand_ops", ops_done, 1003);

      // Reset while waiting for the idx 1 response.
      rdy_mode = 0; dly_mode = 3; oready_mode = 0;
      base = acc_cnt;
      run_op(rnd117(), rnd117(), 1'b0);
      n = 0;
      while (acc_cnt < base + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("wait_idx1_timeout");
      @(negedge clk);
      chk("pre_rst_req_valid", bus.sub_req_valid, 0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("abort");
      chk("abort_err", bus.err_rsp, 0);
      exp_q.delete();
      req_q.delete();
      acc_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (rsp_cnt != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("late_rsp_err", bus.err_rsp, 1);
      chk("late_rsp_prods", {bus.prod_ee, bus.prod_eo, bus.prod_oe, bus.prod_oo}, 0);

      // Clear, then a stray all-ones response while idle.
      rst = 1'b1;
      @(negedge clk);
      chk("reclear_err", bus.err_rsp, 0);
      rst = 1'b0;
      dly_mode = 0;
      repeat (2) @(negedge clk);
      inject = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_rsp_err", bus.err_rsp, 1);
      chk("idle_rsp_prods", {bus.prod_ee, bus.prod_eo, bus.prod_oe, bus.prod_oo}, 0);
      run_op(rnd117(), rnd117(), 1'b1);
      drain();
      chk("err_sticky", bus.err_rsp, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/obs_split_sched_117bit.md
Name: obs_split_sched_117bit

Overview:
- Front end of the L4 odd/even-split (OBS) polynomial multiplier stage; the counterpart of the overlap recombiner.
- Accepts two 117-bit GF(2)[x] operands and splits each into even and odd coefficient halves.
- Schedules the four half-products (ee, eo, oe, oo) one at a time onto a single shared 59-bit sub-multiplier through a request/response handshake.
- Holds the four 117-bit sub-products on registered outputs, wired as overlap inputs 1..4, until downstream accepts them.

Parameters:
- n, 118, stage size; operands and sub-products are n-1 bits wide.
- H, 59, half-operand width, n/2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- A_in  in  n-1  operand A; bit i is the coefficient of x^i.
- B_in  in  n-1  operand B.
- sub_req_valid  out  1  request to the sub-multiplier.
- sub_req_ready  in  1  sub-multiplier accepts the request.
- sub_a  out  H  sub-multiplier operand a.
- sub_b  out  H  sub-multiplier operand b.
- sub_rsp_valid  in  1  sub-product valid, one pulse per accepted request.
- sub_rsp  in  n-1  sub-product a*b, 2H-1 bits.
- out_valid  out  1  four products valid.
- out_ready  in  1  downstream accepts the products.
- prod_ee  out  n-1  Ae*Be, feeds overlap input 1.
- prod_eo  out  n-1  Ae*Bo, feeds overlap input 2.
- prod_oe  out  n-1  Ao*Be, feeds overlap input 3.
- prod_oo  out  n-1  Ao*Bo, feeds overlap input 4.
- err_rsp  out  1  sticky flag: a response arrived when none was outstanding.

Behaviour:
- Split:
  - Ae[j] = A[2j] for j = 0..58.
  - Ao[j] = A[2j+1] for j = 0..57; Ao[58] = 0.
  - B splits the same way into Be and Bo.
  - A and B are captured into registers on input acceptance; the split is taken from the captured copies.
- Reset (async, rst=1): state IDLE, idx=0, captured operands and all products = 0, in_ready=0 while rst is high, sub_req_valid=0, out_valid=0, err_rsp=0, sub_a=sub_b=0.
- FSM states: IDLE, ISSUE, WAIT, DONE. 2-bit idx selects the request:
  - idx 0: (Ae, Be)
  - idx 1: (Ae, Bo)
  - idx 2: (Ao, Be)
  - idx 3: (Ao, Bo)
- IDLE:
  - in_ready=1.
  - in_valid & in_ready: capture operands, idx=0, go to ISSUE.
- ISSUE:
  - sub_req_valid=1; sub_a/sub_b are registered and driven per idx.
  - sub_a/sub_b stay stable until sub_req_ready is seen.
  - On sub_req_valid & sub_req_ready, go to WAIT.
- WAIT:
  - sub_req_valid=0.
  - On sub_rsp_valid, store sub_rsp into the product selected by idx.
  - If idx==3, go to DONE; otherwise idx+1 and go to ISSUE.
  - Waits indefinitely for the response; no timeout.
- DONE:
  - out_valid=1; all products are held stable.
  - On out_ready, go to IDLE with out_valid=0 next cycle.
  - Products keep their values after the handshake until overwritten by the next operation.
- Response handling:
  - sub_rsp_valid in IDLE, ISSUE or DONE is ignored for data and sets err_rsp; err_rsp clears only on reset.
  - At most one request is outstanding. Responses are in order; the sub-multiplier must not respond in the same cycle its request is accepted.
- in_ready=0 in every state except IDLE; there is no combinational path from any input to in_ready or out_valid.
- Minimum latency, with sub_req_ready=1 and the response 1 cycle after acceptance:
  - Input accepted in cycle 0.
  - Requests accepted in cycles 1, 3, 5, 7; responses in cycles 2, 4, 6, 8.
  - out_valid=1 in cycle 9. Throughput is one operation per 10 cycles.
- prod_oo[116] is always 0 for a correct sub-multiplier; the block stores sub_rsp unmodified and does not check it.
- rst asserted mid-operation: immediate abort to the reset values; any in-flight response after rst deasserts is treated as unexpected (sets err_rsp).

Test Plan:
- A=1, B=1, ideal multiplier model: sub requests in order are (1,1), (1,0), (0,1), (0,0) → prod_ee=1, others 0, out_valid in cycle 9; the overlap output equals 1.
- A=2, B=2 (x*x): requests are (0,0), (0,1), (1,0), (1,1) → prod_oo=1, others 0; the overlap output equals 4 (x^2).
- Random A/B, 1000 operations, random sub_req_ready and response delays (0–6 cycles): overlap(prod_*) equals the reference carry-less 117x117 product; err_rsp stays 0.
- Hold sub_req_ready=0 for 5 cycles at idx 2 → sub_req_valid=1, sub_a=Ao, sub_b=Be stable throughout; hold out_ready=0 for 10 cycles in DONE → products stable, in_ready=0.
- Assert rst for 1 cycle while in WAIT at idx 1 → all outputs return to reset values immediately; a response pulse 2 cycles later sets err_rsp=1 and leaves the products at 0.
- sub_rsp_valid pulse in IDLE with sub_rsp = all-ones → err_rsp=1; the next normal operation still completes correctly.
